// File: rtl/prog_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prog_loader_pkg                                                            |
// | Shared types and constants for the PicoBlaze serial program loader.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package prog_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [3:0] WE_WORD   = 4'b0011;
  localparam logic [3:0] WE_NONE   = 4'b0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_B0     = 3'd3,
    ST_B1     = 3'd4,
    ST_B2     = 3'd5,
    ST_CSUM   = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/prog_loader_wdog.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prog_loader_wdog                                                           |
// | Inter-byte idle counter; pulses o_expired after TIMEOUT idle cycles.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module prog_loader_wdog #(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_limit;

  assign w_at_limit = (r_cnt == CNT_W'(TIMEOUT));

  // Wraps to zero on expiry so the output stays a single-cycle pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear || !i_enable || w_at_limit) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expired = i_enable && w_at_limit;

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prog_loader                                                                |
// | Frames a UART byte stream into 18-bit words for the program BRAM and holds |
// | the CPU in reset until a complete image is loaded.                         |
// | Optional CSUM byte check enabled by PROG_LOADER_CHECKSUM_EN.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module prog_loader #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [17:0]       mem_data,
  output logic [3:0]        mem_we,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  import prog_loader_pkg::*;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [ADDR_W-1:0] r_len, w_len_nxt;
  logic [17:0]       r_data, w_data_nxt;
  logic [3:0]        r_we, w_we_nxt;
  logic              r_cpu_rst, w_cpu_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;
  logic [1:0]        r_len_hi, w_len_hi_nxt;
  logic [1:0]        r_b0, w_b0_nxt;
  logic [7:0]        r_b1, w_b1_nxt;
  logic              w_expired;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        r_sum, w_sum_nxt;
  logic [7:0]        w_sum_add;

  assign w_sum_add = r_sum + rx_data;
`endif

  prog_loader_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (rx_valid),
    .i_enable  (r_state != ST_IDLE),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_len_nxt    = r_len;
    w_data_nxt   = r_data;
    w_we_nxt     = WE_NONE;
    w_cpu_nxt    = r_cpu_rst;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_err_nxt    = r_err;
    w_len_hi_nxt = r_len_hi;
    w_b0_nxt     = r_b0;
    w_b1_nxt     = r_b1;
`ifdef PROG_LOADER_CHECKSUM_EN
    w_sum_nxt    = r_sum;
`endif

    // Address moves on the cycle after a write; the final word's address is held.
    if (r_we == WE_WORD && r_addr != r_len) w_addr_nxt = r_addr + ADDR_W'(1);

    if (rx_valid) begin
`ifdef PROG_LOADER_CHECKSUM_EN
      w_sum_nxt = w_sum_add;
`endif
      case (r_state)
        ST_IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            w_state_nxt = ST_LEN_HI;
            w_busy_nxt  = 1'b1;
            w_cpu_nxt   = 1'b1;
            w_err_nxt   = 1'b0;
            w_addr_nxt  = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            w_sum_nxt   = 8'h00;
`endif
          end
        end
        ST_LEN_HI: begin
          if (rx_data[7:2] != 6'd0) begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
            w_err_nxt   = 1'b1;
          end else begin
            w_len_hi_nxt = rx_data[1:0];
            w_state_nxt  = ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          w_len_nxt   = ADDR_W'({r_len_hi, rx_data});
          w_state_nxt = ST_B0;
        end
        ST_B0: begin
          w_b0_nxt    = rx_data[1:0];
          w_state_nxt = ST_B1;
        end
        ST_B1: begin
          w_b1_nxt    = rx_data;
          w_state_nxt = ST_B2;
        end
        ST_B2: begin
          w_data_nxt = {r_b0, r_b1, rx_data};
          w_we_nxt   = WE_WORD;
          if (r_addr == r_len) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            w_state_nxt = ST_CSUM;
`else
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
            w_cpu_nxt   = 1'b0;
            w_done_nxt  = 1'b1;
`endif
          end else begin
            w_state_nxt = ST_B0;
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CSUM: begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
          if (w_sum_add == 8'h00) begin
            w_cpu_nxt  = 1'b0;
            w_done_nxt = 1'b1;
          end else begin
            w_err_nxt  = 1'b1;
          end
        end
`endif
        default: w_state_nxt = ST_IDLE;
      endcase
    end else if (w_expired) begin
      w_state_nxt = ST_IDLE;
      w_busy_nxt  = 1'b0;
      w_err_nxt   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr    <= '0;
      r_len     <= '0;
      r_data    <= '0;
      r_we      <= WE_NONE;
      r_cpu_rst <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_len_hi  <= '0;
      r_b0      <= '0;
      r_b1      <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_sum     <= '0;
`endif
    end else begin
      r_addr    <= w_addr_nxt;
      r_len     <= w_len_nxt;
      r_data    <= w_data_nxt;
      r_we      <= w_we_nxt;
      r_cpu_rst <= w_cpu_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_len_hi  <= w_len_hi_nxt;
      r_b0      <= w_b0_nxt;
      r_b1      <= w_b1_nxt;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_sum     <= w_sum_nxt;
`endif
    end
  end

  assign mem_addr  = r_addr;
  assign mem_data  = r_data;
  assign mem_we    = r_we;
  assign cpu_reset = r_cpu_rst;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_prog_loader                                                             |
// | Scoreboard bench for prog_loader; follows PROG_LOADER_CHECKSUM_EN.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_prog_loader;

  localparam int ADDR_W = 10;
  localparam int TO     = 20;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [17:0]       mem_data;
  logic [3:0]        mem_we;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              error;

  prog_loader #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_we    (mem_we),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int                 errors   = 0;
  int                 checks   = 0;
  int                 done_cnt = 0;
  logic               wrap_seen = 1'b0;
  logic               prev_busy = 1'b0;
  logic [ADDR_W-1:0]  prev_addr = '0;
  logic [ADDR_W+17:0] sb[$];
  logic [17:0]        img[1024];

  // One clock: drive, take the edge, then sample and score any write.
  task automatic step(input logic v, input logic [7:0] d);
    logic [ADDR_W+17:0] exp;
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    if (mem_we !== 4'b0000) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected we=%b addr=%0d data=%h", mem_we, mem_addr, mem_data);
      end else begin
        exp = sb.pop_front();
        if ({mem_we, mem_addr, mem_data} !== {4'b0011, exp}) begin
          errors++;
          $display("FAIL write we=%b addr=%0d data=%h exp we=0011 addr=%0d data=%h",
                   mem_we, mem_addr, mem_data, exp[ADDR_W+17:18], exp[17:0]);
        end
      end
    end
    if (done === 1'b1) done_cnt++;
    if (prev_busy && busy === 1'b1 && prev_addr == ADDR_W'(1023) && mem_addr == '0)
      wrap_seen = 1'b1;
    prev_busy = busy;
    prev_addr = mem_addr;
  endtask

  // Sends a frame built from img[0..n-1]; stop_at >= 0 truncates after that many bytes.
  task automatic send_frame(input int n, input logic [7:0] csum_delta, input int stop_at);
    logic [7:0] fr[$];
    logic [7:0] sum;
    logic [9:0] len;
    len = 10'(n - 1);
    fr.push_back(8'hA5);
    fr.push_back({6'd0, len[9:8]});
    fr.push_back(len[7:0]);
    for (int i = 0; i < n; i++) begin
      fr.push_back({6'h2B, img[i][17:16]});
      fr.push_back(img[i][15:8]);
      fr.push_back(img[i][7:0]);
    end
    sum = 8'h00;
    for (int k = 1; k < fr.size(); k++) sum = sum + fr[k];
`ifdef PROG_LOADER_CHECKSUM_EN
    fr.push_back(8'h00 - sum + csum_delta);
`else
    if (csum_delta != 8'h00 && sum == 8'h00) fr.push_back(8'h00);
`endif
    for (int k = 0; k < fr.size() && (stop_at < 0 || k < stop_at); k++) begin
      if (k >= 3 && k < 3 + 3 * n && (k - 3) % 3 == 2)
        sb.push_back({ADDR_W'((k - 3) / 3), img[(k - 3) / 3]});
      step(1'b1, fr[k]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mem_addr, mem_data, mem_we, cpu_reset, busy, done, error} !== '0) begin
      errors++;
      $display("FAIL reset_values got addr=%0d data=%h we=%b cpu=%b busy=%b done=%b err=%b exp all 0",
               mem_addr, mem_data, mem_we, cpu_reset, busy, done, error);
    end
    reset = 1'b0;
    step(1'b0, 8'h00);
  endtask

  task automatic test_basic_load();
    int d0;
    img[0] = 18'h3FFFF;
    img[1] = 18'h00000;
    img[2] = 18'h12345;
    d0 = done_cnt;
    send_frame(3, 8'h00, -1);
    checks++;
    if (done !== 1'b1 || cpu_reset !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL basic_end done=%b cpu=%b busy=%b err=%b exp 1 0 0 0", done, cpu_reset, busy, error);
    end
    step(1'b0, 8'h00);
    checks++;
    if (done !== 1'b0 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL basic_done_pulse done=%b pulses=%0d exp done=0 pulses=1", done, done_cnt - d0);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL basic_writes_missing left=%0d exp 0", sb.size());
    end
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_bad_csum();
    int d0;
    d0 = done_cnt;
    send_frame(3, 8'h01, -1);
    checks++;
    if (error !== 1'b1 || cpu_reset !== 1'b1 || busy !== 1'b0 || done_cnt != d0) begin
      errors++;
      $display("FAIL csum_bad err=%b cpu=%b busy=%b pulses=%0d exp 1 1 0 0",
               error, cpu_reset, busy, done_cnt - d0);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL csum_bad_writes left=%0d exp 0", sb.size());
    end
    send_frame(3, 8'h00, -1);
    checks++;
    if (error !== 1'b0 || cpu_reset !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL csum_recover err=%b cpu=%b done=%b exp 0 0 1", error, cpu_reset, done);
    end
    step(1'b0, 8'h00);
  endtask
`endif

  task automatic test_bad_len();
    step(1'b1, 8'hA5);
    checks++;
    if (busy !== 1'b1 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL sync_rise busy=%b cpu=%b exp 1 1", busy, cpu_reset);
    end
    step(1'b1, 8'h04);
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL bad_len err=%b busy=%b cpu=%b exp 1 0 1", error, busy, cpu_reset);
    end
    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
    step(1'b0, 8'h00);
    checks++;
    if (busy !== 1'b0 || error !== 1'b1) begin
      errors++;
      $display("FAIL bad_len_idle busy=%b err=%b exp 0 1", busy, error);
    end
  endtask

  task automatic test_timeout();
    step(1'b1, 8'hA5);
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL sync_clears_error err=%b exp 0", error);
    end
    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
    step(1'b1, 8'h01);
    step(1'b1, 8'h23);
    repeat (TO) step(1'b0, 8'h00);
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early err=%b busy=%b exp 0 1", error, busy);
    end
    step(1'b0, 8'h00);
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL timeout err=%b busy=%b cpu=%b exp 1 0 1", error, busy, cpu_reset);
    end
    // Same stall, but B2 lands on the expiry cycle.
    step(1'b1, 8'hA5);
    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
    step(1'b1, 8'h01);
    step(1'b1, 8'h23);
    repeat (TO) step(1'b0, 8'h00);
    sb.push_back({ADDR_W'(0), 18'h12367});
    step(1'b1, 8'h67);
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_byte_wins err=%b exp 0", error);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    step(1'b1, 8'h00 - 8'h8B);
`endif
    checks++;
    if (done !== 1'b1 || cpu_reset !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL timeout_byte_wins_done done=%b cpu=%b left=%0d exp 1 0 0", done, cpu_reset, sb.size());
    end
    step(1'b0, 8'h00);
  endtask

  task automatic test_full();
    for (int i = 0; i < 1024; i++) img[i] = 18'($urandom);
    wrap_seen = 1'b0;
    step(1'b1, 8'h12);
    step(1'b1, 8'h00);
    step(1'b1, 8'h5A);
    checks++;
    if (busy !== 1'b0 || cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL idle_garbage busy=%b cpu=%b exp 0 0", busy, cpu_reset);
    end
    send_frame(1024, 8'h00, -1);
    checks++;
    if (done !== 1'b1 || mem_addr !== ADDR_W'(1023) || sb.size() != 0) begin
      errors++;
      $display("FAIL full_end done=%b addr=%0d left=%0d exp 1 1023 0", done, mem_addr, sb.size());
    end
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    checks++;
    if (mem_addr !== ADDR_W'(1023) || wrap_seen !== 1'b0) begin
      errors++;
      $display("FAIL full_hold addr=%0d wrap=%b exp 1023 0", mem_addr, wrap_seen);
    end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 8; i++) img[i] = 18'h10000 + 18'(i * 18'h111);
    send_frame(8, 8'h00, 3 + 3 * 5 + 2);
    checks++;
    if (busy !== 1'b1 || mem_addr !== ADDR_W'(5)) begin
      errors++;
      $display("FAIL midframe_pre busy=%b addr=%0d exp 1 5", busy, mem_addr);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_addr, mem_data, mem_we, cpu_reset, busy, done, error} !== '0) begin
      errors++;
      $display("FAIL midframe_reset addr=%0d data=%h we=%b cpu=%b busy=%b done=%b err=%b exp all 0",
               mem_addr, mem_data, mem_we, cpu_reset, busy, done, error);
    end
    step(1'b1, 8'h55);
    step(1'b1, 8'h66);
    reset = 1'b0;
    step(1'b1, 8'h77);
    step(1'b1, 8'h11);
    step(1'b0, 8'h00);
    checks++;
    if (busy !== 1'b0 || cpu_reset !== 1'b0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL midframe_after busy=%b cpu=%b addr=%0d exp 0 0 0", busy, cpu_reset, mem_addr);
    end
    img[0] = 18'h2AAAA;
    img[1] = 18'h15555;
    send_frame(2, 8'h00, -1);
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL midframe_reload done=%b err=%b left=%0d exp 1 0 0", done, error, sb.size());
    end
    step(1'b0, 8'h00);
  endtask

  initial begin
    test_reset();
    test_basic_load();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_bad_csum();
`endif
    test_bad_len();
    test_timeout();
    test_full();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
